shop_cmd_framer: RTL
====================

# shop_cmd_framer

Command framer that sits in front of the shop database and drives its command port. It receives a byte-wide ASCII line stream (`<user hex digit><SP><command chars><LF>`) and assembles it into the parallel user/command word the shop consumes. It presents each command using the shop's strobe protocol: `o_u`/`o_a` are stable one full cycle before a one-cycle `o_rdy` pulse and held through it. Malformed lines are discarded and flagged.

## Interface
- `I_A_NUM_ASCII_CHARS`, 7, max command characters; must fit the longest command key.
- `I_A_NUM_BITS`, `I_A_NUM_ASCII_CHARS*8`, width of `o_a`.
- `I_U_NUM_BITS`, 4, width of `o_u` (max 4).
- `TERM_CHAR`, 8'h0A, line terminator.
- `SEP_CHAR`, 8'h20, user/command separator.

Ports:
- `i_clk` in 1: single clock, rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_byte_vld` in 1: `i_byte` valid.
- `i_byte` in 8: ASCII byte.
- `o_byte_rdy` out 1: framer accepts a byte this cycle. A byte transfers on a rising edge where `i_byte_vld && o_byte_rdy`.
- `o_u` out `I_U_NUM_BITS`: user id of the last framed command.
- `o_a` out `I_A_NUM_BITS`: command ASCII, right-aligned (last char in [7:0]), zero-padded high, same layout as a Verilog string literal.
- `o_rdy` out 1: one-cycle command strobe.
- `o_err` out 1: one-cycle malformed-line flag.

## Operation
- **States:** IDLE, SEP, CMD, SETUP, PULSE, DRAIN. Internal registers: accumulator `acc` (`I_A_NUM_BITS`), count `cnt` (0..`I_A_NUM_ASCII_CHARS`), user latch `u_acc`.
- **IDLE** (accepted byte):
  - Hex digit ('0'-'9', 'A'-'F', 'a'-'f') with value < 2**`I_U_NUM_BITS`: `u_acc` <= value, go to SEP.
  - `TERM_CHAR`: stay in IDLE; a blank line raises no error.
  - Anything else: `o_err`, go to DRAIN.
- **SEP:**
  - `SEP_CHAR`: `acc` <= 0, `cnt` <= 0, go to CMD.
  - `TERM_CHAR`: `o_err`, go to IDLE.
  - Anything else: `o_err`, go to DRAIN.
- **CMD:**
  - `TERM_CHAR` with `cnt`==0: `o_err`, go to IDLE.
  - `TERM_CHAR` with `cnt`>0: `o_a` <= `acc`, `o_u` <= `u_acc`, go to SETUP.
  - Other byte with `cnt` == `I_A_NUM_ASCII_CHARS`: `o_err`, go to DRAIN (overflow).
  - Other byte otherwise: `acc` <= {`acc`[`I_A_NUM_BITS`-9:0], byte}, `cnt`++.
- **SETUP:** always go to PULSE. **PULSE:** `o_rdy`=1, then go to IDLE.
- **DRAIN:** discard bytes until `TERM_CHAR`, which is consumed; then go to IDLE. No further `o_err` while draining.
- `o_byte_rdy` = 1 in IDLE, SEP, CMD and DRAIN; 0 in SETUP and PULSE. Upstream holds its byte while `o_byte_rdy`=0; no byte is lost.
- `o_a` and `o_u` change only on entry to SETUP. They hold the last command otherwise and are never exposed mid-assembly.
- `o_rdy` and `o_err` are registered and mutually exclusive.

## Timing
- **Reset:** `i_reset` sampled high at an edge forces state IDLE and clears `acc`, `cnt`, `u_acc`, `o_u`, `o_a`, `o_rdy` and `o_err` to 0 at that edge.
  - Bytes presented while `i_reset`=1 are ignored.
  - `o_byte_rdy`=1 from the first cycle after reset.
- **Reset mid-line** (any state, including SETUP/PULSE): the line is abandoned, no `o_rdy` is issued, and outputs clear.
- **Command latency:** LF accepted at edge k. `o_a`/`o_u` update at edge k. `o_rdy`=1 from edge k+1 to k+2. The framer is in IDLE and accepting again from edge k+2.
- **Minimum spacing:** one command per (line length + 2) cycles at full input rate.
- **Error flag:** `o_err`=1 for exactly the cycle after the edge that accepts the offending byte.
- **Max-length command:** exactly `I_A_NUM_ASCII_CHARS` chars is legal and fills `o_a` completely.

## Test plan
1. **Basic command.** Reset 2 cycles, then stream "4 Login\n" with `i_byte_vld` held high.
   - Required: `o_u`=4, `o_a`=56'h0000_4C6F_6769_6E.
   - Required: `o_rdy` high for 1 cycle, one cycle after `o_a` updates; `o_err` never asserts.
2. **Maximum length.** Stream "5 AddItem\n".
   - Required: `o_u`=5, `o_a`=56'h4164_6449_7465_6D, one `o_rdy` pulse.
3. **Overflow then recovery.** Stream "6 Logout12\n" then "7 Buy\n".
   - Required: `o_err` pulse after the 8th command char ('2'); no `o_rdy` for the first line.
   - Required: then `o_u`=7, `o_a`=56'h42_7579, one `o_rdy`.
4. **Malformed lines.** Stream "G Buy\n", then "\n", then "3\n", then "3 \n".
   - Required: exactly three `o_err` pulses (the bare "\n" raises none); zero `o_rdy` pulses.
   - Required: `o_u`/`o_a` keep their previous values throughout.
5. **Back-to-back lines.** Stream "1 Buy\n2 DelUsr\n" with `i_byte_vld` continuously high.
   - Required: `o_byte_rdy` low exactly 2 cycles after each LF; both commands issued in order.
   - Required: `o_a`=56'h42_7579, then 56'h44_656C_5573_72; no byte dropped.
6. **Reset mid-line.** Stream "2 Ad", assert `i_reset` for 1 cycle, then stream "1 Buy\n".
   - Required: all outputs 0 after the reset edge; no `o_rdy` for the aborted line.
   - Required: then `o_u`=1, `o_a`=56'h42_7579.

Source files
------------

// File: rtl/shop_cmd_framer.sv
// Purpose : frames "<hex user><SP><command><LF>" byte lines into the parallel user/command word for the shop.
// Latency : o_a/o_u update on the edge that accepts LF; o_rdy pulses for one cycle starting one edge later.
// Backpr. : o_byte_rdy drops for the 2 cycles after an accepted LF; upstream must hold its byte meanwhile.
//
// Ports:
//   i_clk, i_reset      clock (rising edge) and synchronous active-high reset
//   i_byte_vld, i_byte  ASCII byte stream; a byte transfers when i_byte_vld && o_byte_rdy
//   o_byte_rdy          framer can take a byte this cycle
//   o_u, o_a            user id and right-aligned, zero-padded command text of the last good line
//   o_rdy               one-cycle command strobe (o_u/o_a already stable for a full cycle)
//   o_err               one-cycle flag for a malformed or overlong line
module shop_cmd_framer #(
  parameter int          I_A_NUM_ASCII_CHARS = 7,
  parameter int          I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
  parameter int          I_U_NUM_BITS        = 4,
  parameter logic [7:0]  TERM_CHAR           = 8'h0A,
  parameter logic [7:0]  SEP_CHAR            = 8'h20
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_byte_vld,
  input  logic [7:0]              i_byte,
  output logic                    o_byte_rdy,
  output logic [I_U_NUM_BITS-1:0] o_u,
  output logic [I_A_NUM_BITS-1:0] o_a,
  output logic                    o_rdy,
  output logic                    o_err
);

  localparam int CW = $clog2(I_A_NUM_ASCII_CHARS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEP   = 3'd1,
    CMD   = 3'd2,
    SETUP = 3'd3,
    PULSE = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t                  state;
  logic [I_A_NUM_BITS-1:0] acc;
  logic [CW-1:0]           cnt;
  logic [I_U_NUM_BITS-1:0] u_acc;

  // Bit 4 flags a legal hex character, bits 3:0 carry its value.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  logic       xfer;
  logic [4:0] hex;
  logic       user_ok;
  logic       is_term;
  logic       is_sep;

  assign xfer    = i_byte_vld && o_byte_rdy;
  assign hex     = hex_decode(i_byte);
  // Narrow user fields reject hex digits that do not fit.
  assign user_ok = hex[4] && (int'(hex[3:0]) < (1 << I_U_NUM_BITS));
  assign is_term = (i_byte == TERM_CHAR);
  assign is_sep  = (i_byte == SEP_CHAR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      u_acc      <= '0;
      o_u        <= '0;
      o_a        <= '0;
      o_rdy      <= 1'b0;
      o_err      <= 1'b0;
      o_byte_rdy <= 1'b1;
    end else begin
      o_rdy      <= 1'b0;
      o_err      <= 1'b0;
      // Registered ready tracks the next state: only SETUP and PULSE stall input.
      o_byte_rdy <= 1'b1;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (user_ok) begin
              u_acc <= hex[I_U_NUM_BITS-1:0];
              state <= SEP;
            end else if (!is_term) begin
              o_err <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        SEP: begin
          if (xfer) begin
            if (is_sep) begin
              acc   <= '0;
              cnt   <= '0;
              state <= CMD;
            end else begin
              o_err <= 1'b1;
              // A terminator already ends the line, so there is nothing to drain.
              state <= is_term ? IDLE : DRAIN;
            end
          end
        end
        CMD: begin
          if (xfer) begin
            if (is_term) begin
              if (cnt == '0) begin
                o_err <= 1'b1;
                state <= IDLE;
              end else begin
                o_a        <= acc;
                o_u        <= u_acc;
                o_byte_rdy <= 1'b0;
                state      <= SETUP;
              end
            end else if (cnt == CW'(I_A_NUM_ASCII_CHARS)) begin
              o_err <= 1'b1;
              state <= DRAIN;
            end else begin
              acc <= {acc[I_A_NUM_BITS-9:0], i_byte};
              cnt <= cnt + CW'(1);
            end
          end
        end
        SETUP: begin
          // o_a/o_u have been stable for this whole cycle; strobe next.
          o_rdy      <= 1'b1;
          o_byte_rdy <= 1'b0;
          state      <= PULSE;
        end
        PULSE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (xfer && is_term) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
